// File: rtl/jump_irq_gen_if.sv
// Interrupt offer handshake between jump_irq_gen (master) and the CPU (slave).
interface jump_irq_gen_if;
  logic [31:0] interrupt_instruction;
  logic        irq_valid;
  logic        irq_ack;

  modport master (
    output interrupt_instruction,
    output irq_valid,
    input  irq_ack
  );

  modport slave (
    input  interrupt_instruction,
    input  irq_valid,
    output irq_ack
  );
endinterface

// File: rtl/jump_irq_gen.sv
// Jump key front-end: sync, debounce, press counting, one frame-aligned interrupt per tick.
// Optional debounce filter is built when JUMP_IRQ_DEBOUNCE_EN is defined.
module jump_irq_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] JUMP_INSTR      = 32'h2800_0001,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jump_key,
  input  logic                  frame_rt_clk,
  jump_irq_gen_if.master        irq,
  output logic [1:0]            pending_count,
  output logic                  press_dropped
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [1:0] key_ff;
  logic [1:0] frame_ff;
  logic       key_sync;
  logic       frame_sync;
  logic       key_deb;
  logic       key_deb_q;
  logic       press_evt;
  logic       frame_q;
  logic       frame_tick;
  logic       dec;
  logic [0:0] state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_ff   <= '0;
      frame_ff <= '0;
    end else begin
      key_ff   <= {key_ff[0], jump_key};
      frame_ff <= {frame_ff[0], frame_rt_clk};
    end
  end

  assign key_sync   = key_ff[1];
  assign frame_sync = frame_ff[1];

`ifdef JUMP_IRQ_DEBOUNCE_EN
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt;

  // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      key_deb <= 1'b0;
    end else if (key_sync != key_deb) begin
      if (deb_cnt == CNT_LAST) begin
        key_deb <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end
`else
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_cfg_unused
  end

  assign key_deb = key_sync;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_deb_q  <= 1'b0;
      press_evt  <= 1'b0;
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      key_deb_q  <= key_deb;
      press_evt  <= key_deb & ~key_deb_q;
      frame_q    <= frame_sync;
      frame_tick <= frame_sync & ~frame_q;
    end
  end

  assign dec = irq.irq_valid & irq.irq_ack;

  // A press coinciding with an ack nets to zero and never counts as dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_count <= '0;
      press_dropped <= 1'b0;
    end else begin
      unique case ({press_evt, dec})
        2'b10: begin
          if (pending_count == 2'd3) press_dropped <= 1'b1;
          else                       pending_count <= pending_count + 2'd1;
        end
        2'b01:   pending_count <= pending_count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                     <= IDLE;
      irq.irq_valid             <= 1'b0;
      irq.interrupt_instruction <= NOP_INSTR;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick && pending_count != 2'd0) begin
            state                     <= ISSUE;
            irq.irq_valid             <= 1'b1;
            irq.interrupt_instruction <= JUMP_INSTR;
          end
        end
        ISSUE: begin
          if (irq.irq_ack) begin
            state                     <= IDLE;
            irq.irq_valid             <= 1'b0;
            irq.interrupt_instruction <= NOP_INSTR;
          end
        end
        default: begin
          state                     <= IDLE;
          irq.irq_valid             <= 1'b0;
          irq.interrupt_instruction <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_irq_gen.sv
// Directed self-checking bench for jump_irq_gen; expectations follow JUMP_IRQ_DEBOUNCE_EN.
module tb_jump_irq_gen;

`ifdef JUMP_IRQ_DEBOUNCE_EN
  localparam int PRESS_LAT = 8;
  localparam int HOLD      = 10;
`else
  localparam int PRESS_LAT = 4;
  localparam int HOLD      = 1;
`endif
  localparam logic [31:0] JUMP = 32'h2800_0001;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic       clock;
  logic       reset;
  logic       jump_key;
  logic       frame_rt_clk;
  logic [1:0] pending_count;
  logic       press_dropped;

  int n_checks = 0;
  int n_pass   = 0;

  jump_irq_gen_if irq_bus ();

  jump_irq_gen #(
    .DEBOUNCE_CYCLES (4),
    .JUMP_INSTR      (JUMP),
    .NOP_INSTR       (NOP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .jump_key      (jump_key),
    .frame_rt_clk  (frame_rt_clk),
    .irq           (irq_bus),
    .pending_count (pending_count),
    .press_dropped (press_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_key();
    jump_key = 1'b1;
    tick(HOLD);
    jump_key = 1'b0;
    tick(12);
  endtask

  // Rising edge on frame_rt_clk; returns on the cycle irq_valid should rise.
  task automatic frame_pulse();
    frame_rt_clk = 1'b1;
    tick(4);
    frame_rt_clk = 1'b0;
  endtask

  task automatic ack_once();
    irq_bus.irq_ack = 1'b1;
    tick(1);
    irq_bus.irq_ack = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"},   irq_bus.interrupt_instruction, NOP);
    check({tag, "_valid"},   {31'd0, irq_bus.irq_valid}, 32'd0);
    check({tag, "_count"},   {30'd0, pending_count}, 32'd0);
    check({tag, "_dropped"}, {31'd0, press_dropped}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    jump_key = 1'b0;
    frame_rt_clk = 1'b0;
    irq_bus.irq_ack = 1'b0;
    tick(2);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(2);

    // First accepted press, with exact latency
`ifdef JUMP_IRQ_DEBOUNCE_EN
    jump_key = 1'b1;
    tick(3);
    jump_key = 1'b0;
    tick(12);
    check("glitch_count", {30'd0, pending_count}, 32'd0);
    jump_key = 1'b1;
    tick(PRESS_LAT - 1);
    check("press_early", {30'd0, pending_count}, 32'd0);
    tick(1);
    check("press_count", {30'd0, pending_count}, 32'd1);
    tick(2);
    jump_key = 1'b0;
    tick(12);
`else
    jump_key = 1'b1;
    tick(1);
    jump_key = 1'b0;
    tick(PRESS_LAT - 2);
    check("press_early", {30'd0, pending_count}, 32'd0);
    tick(1);
    check("press_count", {30'd0, pending_count}, 32'd1);
    tick(12);
`endif

    // Issue four cycles after the frame edge, held until ack
    frame_rt_clk = 1'b1;
    tick(3);
    check("issue_early", {31'd0, irq_bus.irq_valid}, 32'd0);
    frame_rt_clk = 1'b0;
    tick(1);
    check("issue_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    check("issue_instr", irq_bus.interrupt_instruction, JUMP);
    tick(5);
    check("hold_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    check("hold_instr", irq_bus.interrupt_instruction, JUMP);
    check("hold_count", {30'd0, pending_count}, 32'd1);
    ack_once();
    check("ack_valid", {31'd0, irq_bus.irq_valid}, 32'd0);
    check("ack_instr", irq_bus.interrupt_instruction, NOP);
    check("ack_count", {30'd0, pending_count}, 32'd0);

    // One interrupt per frame tick
    press_key();
    press_key();
    check("two_count", {30'd0, pending_count}, 32'd2);
    frame_pulse();
    check("f1_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    ack_once();
    check("f1_count", {30'd0, pending_count}, 32'd1);
    tick(10);
    check("f1_no_second", {31'd0, irq_bus.irq_valid}, 32'd0);
    frame_pulse();
    check("f2_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    ack_once();
    check("f2_count", {30'd0, pending_count}, 32'd0);

    // Saturation, coincident press/ack, then overflow
    press_key();
    press_key();
    press_key();
    check("sat_count", {30'd0, pending_count}, 32'd3);
    check("sat_dropped", {31'd0, press_dropped}, 32'd0);
    frame_pulse();
    check("sat_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    jump_key = 1'b1;
    tick(PRESS_LAT - 1);
    irq_bus.irq_ack = 1'b1;
    tick(1);
    irq_bus.irq_ack = 1'b0;
    jump_key = 1'b0;
    check("coinc_count", {30'd0, pending_count}, 32'd3);
    check("coinc_dropped", {31'd0, press_dropped}, 32'd0);
    check("coinc_valid", {31'd0, irq_bus.irq_valid}, 32'd0);
    tick(12);
    press_key();
    check("ovf_count", {30'd0, pending_count}, 32'd3);
    check("ovf_dropped", {31'd0, press_dropped}, 32'd1);

    // Asynchronous reset while an offer is outstanding
    frame_pulse();
    check("pre_rst_valid", {31'd0, irq_bus.irq_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick(2);
    reset = 1'b0;
    tick(2);
    frame_pulse();
    tick(4);
    check("post_rst_f1", {31'd0, irq_bus.irq_valid}, 32'd0);
    frame_pulse();
    tick(4);
    check("post_rst_f2", {31'd0, irq_bus.irq_valid}, 32'd0);
    press_key();
    check("post_rst_count", {30'd0, pending_count}, 32'd1);
    frame_pulse();
    check("post_rst_issue", irq_bus.interrupt_instruction, JUMP);
    ack_once();
    check("post_rst_done", {30'd0, pending_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jump_irq_gen.md
# jump_irq_gen

Converts the raw, asynchronous jump push-button into frame-aligned interrupt instructions for the CPU. Sits between the board key input and the CPU's interrupt_instruction input, as the front-end of the input path. Synchronizes and debounces the key, counts presses, and releases at most one interrupt per game frame over a valid/ack handshake. Between frames, or with nothing pending, it drives a NOP.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a key level change (10 ms at 100 MHz). Minimum 1.
- JUMP_INSTR, 32'h2800_0001: instruction word delivered to the CPU for one jump press.
- NOP_INSTR, 32'h0000_0000: instruction word driven whenever no interrupt is being offered.

Ports:
- clock  in  1  system clock, 100 MHz. All state is on the rising edge.
- reset  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- jump_key  in  1  raw push-button level, asynchronous, active-high.
- frame_rt_clk  in  1  60 Hz divided frame clock. Treated as asynchronous data, not as a clock.
- irq_ack  in  1  CPU has consumed the offered instruction this cycle.
- interrupt_instruction  out  32  JUMP_INSTR while irq_valid is high, else NOP_INSTR.
- irq_valid  out  1  interrupt offered.
- pending_count  out  2  accepted presses not yet acknowledged, saturating at 3.
- press_dropped  out  1  sticky flag: a press arrived while pending_count was 3.

## Operation
- Reset values: interrupt_instruction = NOP_INSTR, irq_valid = 0, pending_count = 0, press_dropped = 0. Debounced key = 0, debounce counter = 0, FSM = IDLE.
- Synchronizers: jump_key and frame_rt_clk each pass through a 2-FF synchronizer.
- Debounce:
  - When the synced key differs from the debounced level, the counter increments. Otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the synced value and the counter clears.
  - The counter is ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
- Press event: a registered rising edge of the debounced level. Releases generate nothing.
- Frame tick: a registered rising edge of the synced frame_rt_clk, one cycle wide.
- Pending counter update per cycle, with inc = press event and dec = irq_valid & irq_ack:
  - inc only: +1, saturating at 3. If the count is already 3, set press_dropped instead.
  - dec only: -1.
  - inc and dec together: count unchanged, press_dropped not set.
- FSM:
  - IDLE → ISSUE when frame tick is high and pending_count != 0. The count check uses the registered value, before that cycle's update.
  - ISSUE: irq_valid = 1, instruction = JUMP_INSTR. Held stable until ack.
  - ISSUE → IDLE on irq_ack.
- Frame ticks seen while in ISSUE are ignored (not queued).
- Ack received in IDLE is ignored.
- At most one interrupt is issued per frame tick. Remaining pending presses wait for later ticks.
- irq_ack and irq_valid may be high in the same cycle; the transfer completes that cycle.
- Reset asserted mid-operation, including mid-ISSUE or mid-debounce, returns everything to reset values immediately. No offer survives reset.

## Timing
- jump_key to debounced level: 2 sync cycles plus DEBOUNCE_CYCLES, then 1 cycle to the press event.
- Press event to pending_count update: 1 cycle (registered).
- frame_rt_clk rising edge to frame tick: 3 cycles (2 sync + edge register).
- Frame tick to irq_valid/instruction: 1 cycle.
- Ack cycle to irq_valid = 0, instruction = NOP_INSTR, count decrement: 1 cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- JUMP_IRQ_DEBOUNCE_EN defined: the debounce filter is built as described.
- Not defined:
  - The debounce counter is removed and DEBOUNCE_CYCLES is ignored.
  - The debounced level equals the synchronized key.
  - A press event occurs 1 cycle after the synced rising edge (3 cycles after jump_key).
  - All other behaviour is identical.

## Test plan
- Debounce, with DEBOUNCE_CYCLES=4 and macro defined:
  - Glitch: jump_key high for 3 cycles, then low → pending_count stays 0.
  - Clean press: high for 10 cycles → pending_count = 1 at 2+4+1+1 cycles after the rise.
- Issue and ack:
  - With 1 pending, pulse frame_rt_clk → irq_valid = 1 and interrupt_instruction = 32'h2800_0001, 4 cycles after the edge.
  - Hold irq_ack low for 5 cycles → outputs stay stable.
  - Ack → next cycle irq_valid = 0, instruction = 0, pending_count = 0.
- One interrupt per frame:
  - 2 presses, then 1 frame tick with an immediate ack → pending_count = 1 and no second issue.
  - Next tick → second issue.
- Saturation and overflow:
  - 4 presses with no frame tick → pending_count = 3, press_dropped = 1.
  - A press coinciding with an ack while count = 3 → count stays 3, press_dropped does not newly assert.
- Reset during ISSUE:
  - Assert reset asynchronously while irq_valid = 1 → all outputs return to reset values within the same cycle, without waiting for a clock edge.
  - Frame ticks after release issue nothing until a new press is accepted.
- Macro undefined: a 1-cycle synced key pulse → press event, with pending_count = 1 four cycles after jump_key rises.
